// File: rtl/rle_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : rle_frame_capture
// Description : Receive end of the picture-printer serial pixel link.
//               Samples the 1-bit pixel stream with h_sync/v_sync and
//               re-encodes each frame into alternating-colour run lengths.
//               Runs are queued in a first-word-fall-through FIFO with a
//               valid/ready consumer interface. Frame width, start colour
//               and per-frame segment count are reported alongside.
// Ports       :
//   clk, reset            clock and synchronous active-high reset
//   i_capture_en          arm capture (low = idle, open run discarded)
//   i_clear_flags         pulse clearing the sticky error flags
//   i_pix_in              serial pixel
//   i_h_sync_in           first pixel of a line
//   i_v_sync_in           first pixel of a frame
//   o_seg_data/first/last FIFO head: run length and frame position tags
//   o_seg_valid           FIFO head valid
//   i_seg_ready           consumer accepts head when valid & ready
//   o_frame_start_px      colour of first run of last started frame
//   o_frame_width         cycles between consecutive h_syncs (sat. 255)
//   o_frame_segs          segments in last completed frame
//   o_frame_done          one-cycle pulse when a frame closes
//   o_fifo_overflow       sticky: segment dropped because FIFO full
//   o_run_saturated       sticky: a run exceeded MAX_RUN
// Revision    : 1.0  initial release
// ============================================================================
module rle_frame_capture #(
    parameter int MAX_RUN    = 255,
    parameter int FIFO_DEPTH = 16,
    parameter int SEG_CNT_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_capture_en,
    input  logic                 i_clear_flags,
    input  logic                 i_pix_in,
    input  logic                 i_h_sync_in,
    input  logic                 i_v_sync_in,
    output logic [7:0]           o_seg_data,
    output logic                 o_seg_first,
    output logic                 o_seg_last,
    output logic                 o_seg_valid,
    input  logic                 i_seg_ready,
    output logic                 o_frame_start_px,
    output logic [7:0]           o_frame_width,
    output logic [SEG_CNT_W-1:0] o_frame_segs,
    output logic                 o_frame_done,
    output logic                 o_fifo_overflow,
    output logic                 o_run_saturated
);

    localparam int               c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int               c_ENTRY_W = 10;
    localparam logic [c_ADDR_W:0] c_FIFO_FULL = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]       c_MAX_RUN = 8'(MAX_RUN);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT_VS = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    // FSM-decoded per-cycle actions
    logic w_in_run;       // RUN and still armed this cycle
    logic w_enter;        // first v_sync seen while waiting
    logic w_close_frame;  // v_sync inside RUN closes the frame
    logic w_change;       // colour change inside a frame
    logic w_extend;       // same colour, run grows
    logic w_restart;      // (re)start a frame with the current pixel
    logic w_active;       // cycle belongs to an armed capture

    // run encoder state
    logic [7:0]           r_run_len;
    logic                 r_run_px;
    logic                 r_first_pending;
    logic [SEG_CNT_W-1:0] r_seg_cnt;
    logic [SEG_CNT_W-1:0] w_seg_cnt_inc;
    logic                 w_sat_event;

    // frame reporting
    logic                 r_frame_start_px;
    logic [SEG_CNT_W-1:0] r_frame_segs;
    logic                 r_frame_done;
    logic [7:0]           r_frame_width;
    logic [7:0]           r_w_cnt;
    logic                 r_hs_seen;

    // FIFO
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_ADDR_W:0]    r_count;
    logic                 w_push;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push_ok;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_head;

    // sticky flags
    logic r_fifo_overflow;
    logic r_run_saturated;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_capture_en) begin
                    w_next_state = c_ST_WAIT_VS;
                end
            end
            c_ST_WAIT_VS: begin
                if (!i_capture_en) begin
                    w_next_state = c_ST_IDLE;
                end else if (i_v_sync_in) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!i_capture_en) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_in_run      = (r_state == c_ST_RUN) && i_capture_en;
        w_enter       = (r_state == c_ST_WAIT_VS) && i_capture_en && i_v_sync_in;
        w_close_frame = w_in_run && i_v_sync_in;
        w_change      = w_in_run && !i_v_sync_in && (i_pix_in != r_run_px);
        w_extend      = w_in_run && !i_v_sync_in && (i_pix_in == r_run_px);
        w_restart     = w_enter || w_close_frame;
        // The frame-entry pixel is part of the capture, so an h_sync
        // coinciding with the first v_sync starts the width count.
        w_active      = w_in_run || w_enter;
    end

    // ------------------------------------------------------------------
    // Run encoder
    // ------------------------------------------------------------------
    assign w_seg_cnt_inc = (&r_seg_cnt) ? r_seg_cnt : r_seg_cnt + 1'b1;
    assign w_sat_event   = w_extend && (r_run_len == c_MAX_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_len        <= 8'd0;
            r_run_px         <= 1'b0;
            r_first_pending  <= 1'b0;
            r_seg_cnt        <= '0;
            r_frame_start_px <= 1'b0;
        end else if (w_restart) begin
            r_run_len        <= 8'd1;
            r_run_px         <= i_pix_in;
            r_first_pending  <= 1'b1;
            r_seg_cnt        <= '0;
            r_frame_start_px <= i_pix_in;
        end else if (w_change) begin
            r_run_len       <= 8'd1;
            r_run_px        <= i_pix_in;
            r_first_pending <= 1'b0;
            r_seg_cnt       <= w_seg_cnt_inc;
        end else if (w_extend && !w_sat_event) begin
            r_run_len <= r_run_len + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_segs <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_close_frame;
            if (w_close_frame) begin
                r_frame_segs <= w_seg_cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line width: cycles between consecutive h_syncs while capturing.
    // The count is only trusted after an h_sync seen in the same armed
    // stretch, so leaving the capture invalidates it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_width <= 8'd0;
            r_w_cnt       <= 8'd0;
            r_hs_seen     <= 1'b0;
        end else if (w_active && i_h_sync_in) begin
            if (r_hs_seen) begin
                r_frame_width <= r_w_cnt;
            end
            r_w_cnt   <= 8'd1;
            r_hs_seen <= 1'b1;
        end else if (w_active) begin
            r_w_cnt <= (r_w_cnt == 8'hFF) ? r_w_cnt : r_w_cnt + 8'd1;
        end else begin
            r_hs_seen <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Segment FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    assign w_push      = w_close_frame || w_change;
    assign w_push_data = {r_first_pending, w_close_frame, r_run_len};
    assign w_pop       = (r_count != '0) && i_seg_ready;
    assign w_full      = (r_count == c_FIFO_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set condition beats a simultaneous clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_overflow <= 1'b0;
            r_run_saturated <= 1'b0;
        end else begin
            r_fifo_overflow <= w_drop || (r_fifo_overflow && !i_clear_flags);
            r_run_saturated <= w_sat_event || (r_run_saturated && !i_clear_flags);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head fields are forced to zero while the FIFO is empty so
    // stale storage never shows on the bus.
    // ------------------------------------------------------------------
    assign w_head           = r_mem[r_rd_ptr];
    assign o_seg_valid      = (r_count != '0);
    assign o_seg_data       = o_seg_valid ? w_head[7:0] : 8'd0;
    assign o_seg_last       = o_seg_valid && w_head[8];
    assign o_seg_first      = o_seg_valid && w_head[9];
    assign o_frame_start_px = r_frame_start_px;
    assign o_frame_width    = r_frame_width;
    assign o_frame_segs     = r_frame_segs;
    assign o_frame_done     = r_frame_done;
    assign o_fifo_overflow  = r_fifo_overflow;
    assign o_run_saturated  = r_run_saturated;

endmodule
`default_nettype wire

// File: tb/tb_rle_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rle_frame_capture
// Description : Self-checking bench for rle_frame_capture. A behavioural
//               model tracks runs as plain integer pixel counts, the FIFO as
//               a queue and the line width from absolute cycle numbers.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rle_frame_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0, cf = 1'b0, px = 1'b0, hs = 1'b0, vs = 1'b0, rdy = 1'b1;
    logic [7:0] seg_data;
    logic       seg_first, seg_last, seg_valid;
    logic       start_px, done, ovf, sat;
    logic [7:0] width;
    logic [9:0] fsegs;

    always #5 clk = ~clk;

    rle_frame_capture #(.MAX_RUN(255), .FIFO_DEPTH(16), .SEG_CNT_W(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_capture_en     (ce),
        .i_clear_flags    (cf),
        .i_pix_in         (px),
        .i_h_sync_in      (hs),
        .i_v_sync_in      (vs),
        .o_seg_data       (seg_data),
        .o_seg_first      (seg_first),
        .o_seg_last       (seg_last),
        .o_seg_valid      (seg_valid),
        .i_seg_ready      (rdy),
        .o_frame_start_px (start_px),
        .o_frame_width    (width),
        .o_frame_segs     (fsegs),
        .o_frame_done     (done),
        .o_fifo_overflow  (ovf),
        .o_run_saturated  (sat)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       f;
        logic       l;
        logic [7:0] d;
    } seg_t;

    seg_t exp_q[$];
    int   m_mode;      // 0 idle, 1 waiting for v_sync, 2 capturing
    int   m_run;       // true (unsaturated) length of the open run
    bit   m_run_px;
    int   m_segs;      // closed segments in the open frame
    bit   m_start;
    int   m_fsegs;
    bit   m_done;
    int   m_width;
    bit   m_hs_valid;
    int   m_hs_cyc;
    int   m_cyc = 0;
    bit   m_ovf, m_sat;

    function automatic seg_t mkseg(bit f, bit l, int run);
        seg_t s;
        s.f = f;
        s.l = l;
        s.d = 8'((run > 255) ? 255 : run);
        return s;
    endfunction

    task automatic model_update();
        bit   pop, push, set_ovf, set_sat, active;
        seg_t s;
        m_cyc++;
        if (reset) begin
            exp_q.delete();
            m_mode = 0; m_run = 0; m_run_px = 0; m_segs = 0; m_start = 0;
            m_fsegs = 0; m_done = 0; m_width = 0; m_hs_valid = 0; m_hs_cyc = 0;
            m_ovf = 0; m_sat = 0;
            return;
        end
        pop = (exp_q.size() > 0) && rdy;
        push = 0; set_ovf = 0; set_sat = 0; m_done = 0;
        active = ce && (m_mode == 2 || (m_mode == 1 && vs));
        if (active && hs) begin
            if (m_hs_valid) m_width = ((m_cyc - m_hs_cyc) > 255) ? 255 : (m_cyc - m_hs_cyc);
            m_hs_cyc = m_cyc;
            m_hs_valid = 1;
        end else if (!active) begin
            m_hs_valid = 0;
        end
        case (m_mode)
            0: if (ce) m_mode = 1;
            1: begin
                if (!ce) m_mode = 0;
                else if (vs) begin
                    m_mode = 2; m_run = 1; m_run_px = px; m_start = px; m_segs = 0;
                end
            end
            default: begin
                if (!ce) m_mode = 0;
                else if (vs) begin
                    s = mkseg(m_segs == 0, 1, m_run); push = 1;
                    m_fsegs = (m_segs + 1 > 1023) ? 1023 : m_segs + 1;
                    m_done = 1;
                    m_run = 1; m_run_px = px; m_start = px; m_segs = 0;
                end else if (px != m_run_px) begin
                    s = mkseg(m_segs == 0, 0, m_run); push = 1;
                    m_segs++;
                    m_run = 1; m_run_px = px;
                end else begin
                    m_run++;
                    if (m_run > 255) set_sat = 1;
                end
            end
        endcase
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < 16) exp_q.push_back(s);
            else set_ovf = 1;
        end
        m_ovf = (m_ovf && !cf) || set_ovf;
        m_sat = (m_sat && !cf) || set_sat;
    endtask

    task automatic check_all();
        seg_t h;
        bit   v;
        v = exp_q.size() > 0;
        h = v ? exp_q[0] : seg_t'(0);
        chk("seg_valid", seg_valid, v);
        chk("seg_data", seg_data, h.d);
        chk("seg_first", seg_first, h.f);
        chk("seg_last", seg_last, h.l);
        chk("frame_start_px", start_px, m_start);
        chk("frame_width", width, m_width);
        chk("frame_segs", fsegs, m_fsegs);
        chk("frame_done", done, m_done);
        chk("fifo_overflow", ovf, m_ovf);
        chk("run_saturated", sat, m_sat);
    endtask

    // inputs are changed at the negedge; the model follows the posedge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1; ce = 0; cf = 0; vs = 0; hs = 0; px = 0; rdy = 1;
        step();
        step();
        reset = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       ce, px, vs;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_first, e_last, e_done;
        logic [9:0] e_fsegs;
        logic       e_start;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int cnt;
        int pos, flen, lline;

        tbl[0] = '{1, 0, 0, 0, 8'd0, 0, 0, 0, 10'd0, 0};
        tbl[1] = '{1, 1, 1, 0, 8'd0, 0, 0, 0, 10'd0, 1};
        tbl[2] = '{1, 1, 0, 0, 8'd0, 0, 0, 0, 10'd0, 1};
        tbl[3] = '{1, 1, 0, 0, 8'd0, 0, 0, 0, 10'd0, 1};
        tbl[4] = '{1, 0, 0, 1, 8'd3, 1, 0, 0, 10'd0, 1};
        tbl[5] = '{1, 0, 0, 0, 8'd0, 0, 0, 0, 10'd0, 1};
        tbl[6] = '{1, 1, 0, 1, 8'd2, 0, 0, 0, 10'd0, 1};
        tbl[7] = '{1, 1, 1, 1, 8'd1, 0, 1, 1, 10'd3, 1};
        tbl[8] = '{1, 1, 0, 0, 8'd0, 0, 0, 0, 10'd3, 1};

        // reset values
        do_reset();
        chk("rst_valid", seg_valid, 0);
        chk("rst_width", width, 0);

        // frame 1,1,1,0,0,1 then next v_sync
        for (int i = 0; i < 9; i++) begin
            ce = tbl[i].ce; px = tbl[i].px; vs = tbl[i].vs;
            step();
            chk("tbl_valid", seg_valid, tbl[i].e_valid);
            chk("tbl_data", seg_data, tbl[i].e_data);
            chk("tbl_first", seg_first, tbl[i].e_first);
            chk("tbl_last", seg_last, tbl[i].e_last);
            chk("tbl_done", done, tbl[i].e_done);
            chk("tbl_fsegs", fsegs, tbl[i].e_fsegs);
            chk("tbl_start", start_px, tbl[i].e_start);
        end

        // run saturation: 300 ones then a 0
        do_reset();
        ce = 1; step();
        vs = 1; px = 1; step();
        vs = 0;
        repeat (299) step();
        chk("sat_set", sat, 1);
        px = 0; step();
        chk("sat_seg", seg_data, 255);
        chk("sat_seg_valid", seg_valid, 1);
        cf = 1; step();
        cf = 0;
        chk("sat_cleared", sat, 0);

        // FIFO overflow: consumer stalled, 20 alternating pixels
        do_reset();
        rdy = 0; ce = 1; step();
        vs = 1; px = 0; step();
        vs = 0;
        for (int i = 0; i < 20; i++) begin
            px = (i % 2 == 0); step();
        end
        chk("ovf_set", ovf, 1);
        ce = 0; rdy = 1; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (seg_valid) cnt++;
            step();
        end
        chk("ovf_held", cnt, 16);

        // frame width with h_sync every 41 cycles
        do_reset();
        ce = 1; step();
        for (int i = 0; i <= 41 * 3; i++) begin
            vs = (i == 0); hs = (i % 41 == 0); px = 1'($urandom); rdy = 1'($urandom);
            step();
            if (i == 41) chk("width_2nd_hs", width, 41);
        end
        vs = 0; hs = 0;
        chk("width_41", width, 41);

        // capture_en drop mid-frame, then resume at next v_sync
        do_reset();
        ce = 1; step();
        vs = 1; px = 1; step();
        vs = 0; step();
        px = 0; step();
        step();
        ce = 0; px = 1; step();
        chk("drop_no_push", seg_valid, 0);
        ce = 1;
        for (int i = 0; i < 5; i++) begin
            px = 1'($urandom); step();
            chk("wait_no_push", seg_valid, 0);
        end
        vs = 1; px = 0; step();
        vs = 0; px = 1; step();
        chk("resume_valid", seg_valid, 1);
        chk("resume_first", seg_first, 1);
        chk("resume_data", seg_data, 1);

        // reset mid-RUN with FIFO non-empty
        rdy = 0;
        for (int i = 0; i < 4; i++) begin
            px = ~px; step();
        end
        chk("pre_rst_valid", seg_valid, 1);
        reset = 1; step();
        chk("mid_rst_valid", seg_valid, 0);
        chk("mid_rst_start", start_px, 0);
        chk("mid_rst_segs", fsegs, 0);
        reset = 0; ce = 0; rdy = 1; step();

        // randomized traffic against the model
        pos = 0; flen = 30; lline = 10;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 1499) == 0);
            ce    = ($urandom_range(0, 299) != 0);
            cf    = ($urandom_range(0, 39) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) px = ~px;
            vs = (pos == 0);
            hs = (pos % lline == 0);
            step();
            pos++;
            if (pos == flen) begin
                pos = 0;
                lline = $urandom_range(5, 15);
                flen = lline * $urandom_range(2, 5);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
